// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port vector register file.
package rf_pkg;

  localparam logic [2:0] PPP_ALL    = 3'b000;
  localparam logic [2:0] PPP_HI     = 3'b001;
  localparam logic [2:0] PPP_LO     = 3'b010;
  localparam logic [2:0] PPP_EVEN_B = 3'b011;
  localparam logic [2:0] PPP_ODD_B  = 3'b100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } rf_state_e;

  function automatic logic ppp_valid(input logic [2:0] ppp);
    return ppp <= PPP_ODD_B;
  endfunction

endpackage

// File: rtl/rf_lane_mask.sv
// Decodes a ppp lane select into a per-bit write mask; unused encodings give an empty mask.
module rf_lane_mask
  import rf_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]        ppp,
  output logic [DATA_W-1:0] mask
);

  // HI is the big-endian [0:W/2-1] half; byte parity counts from the least significant byte.
  always_comb begin
    mask = '0;
    case (ppp)
      PPP_ALL: mask = '1;
      PPP_HI:  mask[DATA_W-1:DATA_W/2] = '1;
      PPP_LO:  mask[DATA_W/2-1:0] = '1;
      PPP_EVEN_B: begin
        for (int unsigned b = 0; b < DATA_W / 8; b++)
          if ((b % 2) == 0) mask[b*8 +: 8] = '1;
      end
      PPP_ODD_B: begin
        for (int unsigned b = 0; b < DATA_W / 8; b++)
          if ((b % 2) == 1) mask[b*8 +: 8] = '1;
      end
      default: mask = '0;
    endcase
  end

endmodule

// File: rtl/vreg_file_mp.sv
// Multi-port register file: two lane-selective write ports, forwarded reads,
// pending scoreboard and a sequential soft-clear sweep.
module vreg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 6,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr0_en,
  input  logic [2:0]                 wr0_ppp,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [2:0]                 wr1_ppp,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  output logic                       wr_ready,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       clr_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < DEPTH_X);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend, pend_set, pend_clr;
  rf_state_e         state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic              clr_done_nx;
  logic [DATA_W-1:0] m0, m1, wval0, wval1;
  logic              acc0, acc1;
  logic [IDX_W-1:0]  i0, i1, ip;

  rf_lane_mask #(.DATA_W(DATA_W)) u_mask0 (.ppp(wr0_ppp), .mask(m0));
  rf_lane_mask #(.DATA_W(DATA_W)) u_mask1 (.ppp(wr1_ppp), .mask(m1));

  assign busy     = (state == ST_SWEEP);
  assign wr_ready = ~busy;
  assign acc0     = wr0_en && addr_ok(wr0_addr) && !busy;
  assign acc1     = wr1_en && addr_ok(wr1_addr) && !busy;
  assign i0       = wr0_addr[IDX_W-1:0];
  assign i1       = wr1_addr[IDX_W-1:0];
  assign ip       = rsv_addr[IDX_W-1:0];

  // Same-address writes chain wr1 on top of wr0's result so lanes merge and wr1 wins overlaps.
  always_comb begin
    wval0 = (mem[i0] & ~m0) | (wr0_data & m0);
    wval1 = (((acc0 && (wr0_addr == wr1_addr)) ? wval0 : mem[i1]) & ~m1) | (wr1_data & m1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (busy) mem[ptr[IDX_W-1:0]] <= '0;
      if (acc0) mem[i0] <= wval0;
      if (acc1) mem[i1] <= wval1;
    end
  end

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (acc0 && ppp_valid(wr0_ppp)) pend_clr[i0] = 1'b1;
    if (acc1 && ppp_valid(wr1_ppp)) pend_clr[i1] = 1'b1;
    if (rsv_en && addr_ok(rsv_addr) && !busy) pend_set[ip] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || (state == ST_IDLE && clr_req)) pend <= '0;
    else                                      pend <= (pend & ~pend_clr) | pend_set;
  end

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    clr_done_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nx = ST_SWEEP;
          ptr_nx   = ADDR_W'(1);
        end
      end
      ST_SWEEP: begin
        ptr_nx = ptr + 1'b1;
        if (ptr == LAST) begin
          state_nx    = ST_IDLE;
          clr_done_nx = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      clr_done <= clr_done_nx;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      a = rd_addr[k*ADDR_W +: ADDR_W];
      v = '0;
      if (!rst && addr_ok(a)) begin
        v = mem[a[IDX_W-1:0]];
        if (acc0 && wr0_addr == a) v = (v & ~m0) | (wr0_data & m0);
        if (acc1 && wr1_addr == a) v = (v & ~m1) | (wr1_data & m1);
        rd_pend[k] = pend[a[IDX_W-1:0]];
      end
      rd_data[k*DATA_W +: DATA_W] = v;
    end
  end

endmodule

// File: tb/tb_vreg_file_mp.sv
// Self-checking bench for vreg_file_mp: directed vector table, clear/abort sequences, random vs model.
module tb_vreg_file_mp;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 6;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     wr0_en, wr1_en;
  logic [2:0]               wr0_ppp, wr1_ppp;
  logic [ADDR_W-1:0]        wr0_addr, wr1_addr;
  logic [DATA_W-1:0]        wr0_data, wr1_data;
  logic                     wr_ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     clr_req;
  logic                     busy;
  logic                     clr_done;

  always #5 clk = ~clk;

  vreg_file_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_ppp(wr0_ppp), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_ppp(wr1_ppp), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents, pending flags and the clear progress
  logic [DATA_W-1:0] mm [DEPTH];
  logic [DEPTH-1:0]  mp;
  logic              m_busy = 1'b0;
  logic              m_done = 1'b0;
  int                m_ptr  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lanes(input logic [2:0] ppp);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      logic sel;
      case (ppp)
        3'd0:    sel = 1'b1;
        3'd1:    sel = (b >= 4);
        3'd2:    sel = (b < 4);
        3'd3:    sel = (b % 2 == 0);
        3'd4:    sel = (b % 2 == 1);
        default: sel = 1'b0;
      endcase
      if (sel) m[8*b +: 8] = 8'hFF;
    end
    return m;
  endfunction

  function automatic logic valid_reg(input logic [ADDR_W-1:0] a);
    return (a != 0) && (int'(a) < DEPTH);
  endfunction

  function automatic logic accepted(input logic en, input logic [ADDR_W-1:0] a);
    return en && valid_reg(a) && !m_busy;
  endfunction

  function automatic logic [63:0] m_read(input logic [ADDR_W-1:0] a);
    logic [63:0] v;
    if (rst || !valid_reg(a)) return '0;
    v = mm[a[4:0]];
    if (accepted(wr0_en, wr0_addr) && wr0_addr == a) v = (v & ~lanes(wr0_ppp)) | (wr0_data & lanes(wr0_ppp));
    if (accepted(wr1_en, wr1_addr) && wr1_addr == a) v = (v & ~lanes(wr1_ppp)) | (wr1_data & lanes(wr1_ppp));
    return v;
  endfunction

  function automatic logic m_pend(input logic [ADDR_W-1:0] a);
    if (rst || !valid_reg(a)) return 1'b0;
    return mp[a[4:0]];
  endfunction

  task automatic model_step();
    logic a0, a1, nd;
    a0 = accepted(wr0_en, wr0_addr);
    a1 = accepted(wr1_en, wr1_addr);
    nd = m_busy && (m_ptr == DEPTH - 1);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      mp = '0; m_busy = 1'b0; m_ptr = 0; nd = 1'b0;
    end else if (m_busy) begin
      mm[m_ptr] = '0;
      if (m_ptr == DEPTH - 1) m_busy = 1'b0;
      m_ptr++;
    end else begin
      if (a0) begin
        mm[wr0_addr[4:0]] = (mm[wr0_addr[4:0]] & ~lanes(wr0_ppp)) | (wr0_data & lanes(wr0_ppp));
        if (wr0_ppp <= 3'd4) mp[wr0_addr[4:0]] = 1'b0;
      end
      if (a1) begin
        mm[wr1_addr[4:0]] = (mm[wr1_addr[4:0]] & ~lanes(wr1_ppp)) | (wr1_data & lanes(wr1_ppp));
        if (wr1_ppp <= 3'd4) mp[wr1_addr[4:0]] = 1'b0;
      end
      if (rsv_en && valid_reg(rsv_addr)) mp[rsv_addr[4:0]] = 1'b1;
      if (clr_req) begin
        mp = '0; m_busy = 1'b1; m_ptr = 1;
      end
    end
    m_done = nd;
  endtask

  task automatic check_all();
    for (int k = 0; k < NUM_RD; k++) begin
      chk($sformatf("rd_data%0d", k), rd_data[k*DATA_W +: DATA_W], m_read(rd_addr[k*ADDR_W +: ADDR_W]));
      chk($sformatf("rd_pend%0d", k), 64'(rd_pend[k]), 64'(m_pend(rd_addr[k*ADDR_W +: ADDR_W])));
    end
    chk("busy", 64'(busy), 64'(m_busy));
    chk("wr_ready", 64'(wr_ready), 64'(!m_busy));
    chk("clr_done", 64'(clr_done), 64'(m_done));
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle();
    #1;
    check_all();
    advance();
  endtask

  task automatic idle_inputs();
    wr0_en = 1'b0; wr0_ppp = 3'd0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_ppp = 3'd0; wr1_addr = '0; wr1_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0; rd_addr = '0;
  endtask

  function automatic logic [63:0] pat(input int i, input logic [7:0] tag);
    return {tag, 16'hC0DE, 8'(i), 24'h0BADF0, 8'(i)};
  endfunction

  task automatic load_all(input logic [7:0] tag);
    for (int i = 1; i < DEPTH; i++) begin
      wr0_en = 1'b1; wr0_ppp = 3'd0; wr0_addr = 6'(i); wr0_data = pat(i, tag);
      cycle();
    end
    idle_inputs();
  endtask

  typedef struct {
    logic        w0e; logic [2:0] w0p; logic [5:0] w0a; logic [63:0] w0d;
    logic        w1e; logic [2:0] w1p; logic [5:0] w1a; logic [63:0] w1d;
    logic        rse; logic [5:0] rsa;
    logic [5:0]  ra0; logic [5:0] ra1;
    logic [63:0] e0;  logic [63:0] e1; logic [1:0] ep;
  } vec_t;

  localparam logic [63:0] F64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Z64 = 64'h0;
  localparam logic [63:0] V0  = 64'h1122334455667788;
  localparam logic [63:0] V1  = 64'hBBBBBBBB55AA77AA;
  localparam logic [63:0] V2  = 64'h00BB00BB00AA00AA;
  localparam logic [63:0] V3  = 64'h00BB00BB22222222;
  localparam logic [63:0] V9  = 64'hDEADBEEF0BADF00D;
  localparam logic [63:0] V7  = 64'h0123456789ABCDEF;
  localparam logic [63:0] V7H = 64'hFFFFFFFF89ABCDEF;

  vec_t tbl [16];

  initial begin
    int done_at, busy_cnt, late_done;
    logic [7:0] t;

    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    mp = '0;
    @(negedge clk);

    // Reads are forced to zero while reset is held, then the cleared array reads zero
    for (int a = 0; a < 64; a += 2) begin
      rd_addr = {6'(a + 1), 6'(a)};
      #1;
      chk("rst_rd0", rd_data[63:0], Z64);
      chk("rst_rd1", rd_data[127:64], Z64);
      chk("rst_pend", 64'(rd_pend), Z64);
      advance();
    end
    rst = 1'b0;
    for (int a = 0; a < 64; a += 2) begin
      rd_addr = {6'(a + 1), 6'(a)};
      #1;
      chk("post_rst_rd0", rd_data[63:0], Z64);
      chk("post_rst_rd1", rd_data[127:64], Z64);
      chk("post_rst_pend", 64'(rd_pend), Z64);
      chk("post_rst_ready", 64'(wr_ready), 64'd1);
      chk("post_rst_busy", 64'(busy), Z64);
      advance();
    end

    tbl[0]  = '{1'b1,3'd0,6'd5,V0,  1'b0,3'd0,6'd0,Z64, 1'b0,6'd0,  6'd5,6'd5,  V0,V0,2'b00};
    tbl[1]  = '{1'b0,3'd0,6'd0,Z64, 1'b0,3'd0,6'd0,Z64, 1'b0,6'd0,  6'd5,6'd0,  V0,Z64,2'b00};
    tbl[2]  = '{1'b1,3'd3,6'd5,64'hAAAAAAAAAAAAAAAA, 1'b1,3'd1,6'd5,64'hBBBBBBBBBBBBBBBB,
                1'b0,6'd0, 6'd5,6'd6, V1,Z64,2'b00};
    tbl[3]  = '{1'b0,3'd0,6'd0,Z64, 1'b0,3'd0,6'd0,Z64, 1'b0,6'd0,  6'd5,6'd6,  V1,Z64,2'b00};
    tbl[4]  = '{1'b1,3'd0,6'd0,F64, 1'b1,3'd0,6'd40,F64, 1'b0,6'd0, 6'd0,6'd40, Z64,Z64,2'b00};
    tbl[5]  = '{1'b1,3'd7,6'd5,F64, 1'b0,3'd0,6'd0,Z64, 1'b0,6'd0,  6'd5,6'd0,  V1,Z64,2'b00};
    tbl[6]  = '{1'b0,3'd0,6'd0,Z64, 1'b1,3'd4,6'd5,Z64, 1'b0,6'd0,  6'd5,6'd5,  V2,V2,2'b00};
    tbl[7]  = '{1'b1,3'd2,6'd5,64'h1111111122222222, 1'b1,3'd0,6'd9,V9,
                1'b0,6'd0, 6'd5,6'd9, V3,V9,2'b00};
    tbl[8]  = '{1'b0,3'd0,6'd0,Z64, 1'b0,3'd0,6'd0,Z64, 1'b1,6'd7,  6'd7,6'd5,  Z64,V3,2'b00};
    tbl[9]  = '{1'b0,3'd0,6'd0,Z64, 1'b0,3'd0,6'd0,Z64, 1'b0,6'd0,  6'd7,6'd9,  Z64,V9,2'b01};
    tbl[10] = '{1'b1,3'd0,6'd7,V7,  1'b0,3'd0,6'd0,Z64, 1'b0,6'd0,  6'd7,6'd7,  V7,V7,2'b11};
    tbl[11] = '{1'b0,3'd0,6'd0,Z64, 1'b0,3'd0,6'd0,Z64, 1'b0,6'd0,  6'd7,6'd7,  V7,V7,2'b00};
    tbl[12] = '{1'b0,3'd0,6'd0,Z64, 1'b1,3'd1,6'd7,F64, 1'b1,6'd7,  6'd7,6'd0,  V7H,Z64,2'b00};
    tbl[13] = '{1'b0,3'd0,6'd0,Z64, 1'b0,3'd0,6'd0,Z64, 1'b0,6'd0,  6'd7,6'd3,  V7H,Z64,2'b01};
    tbl[14] = '{1'b1,3'd5,6'd7,Z64, 1'b0,3'd0,6'd0,Z64, 1'b1,6'd40, 6'd7,6'd3,  V7H,Z64,2'b01};
    tbl[15] = '{1'b0,3'd0,6'd0,Z64, 1'b0,3'd0,6'd0,Z64, 1'b0,6'd0,  6'd7,6'd40, V7H,Z64,2'b01};

    for (int i = 0; i < 16; i++) begin
      wr0_en = tbl[i].w0e; wr0_ppp = tbl[i].w0p; wr0_addr = tbl[i].w0a; wr0_data = tbl[i].w0d;
      wr1_en = tbl[i].w1e; wr1_ppp = tbl[i].w1p; wr1_addr = tbl[i].w1a; wr1_data = tbl[i].w1d;
      rsv_en = tbl[i].rse; rsv_addr = tbl[i].rsa;
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      #1;
      chk($sformatf("vec%0d_rd0", i), rd_data[63:0], tbl[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd_data[127:64], tbl[i].e1);
      chk($sformatf("vec%0d_pend", i), 64'(rd_pend), 64'(tbl[i].ep));
      advance();
    end
    idle_inputs();

    // Full soft clear with writes, reserves and a repeated request thrown at it
    load_all(8'h51);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    done_at = -1; busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      wr0_en = (n <= 31); wr0_ppp = 3'd0; wr0_addr = 6'd3; wr0_data = F64;
      rsv_en = (n <= 31); rsv_addr = 6'd4;
      clr_req = (n == 5);
      rd_addr = {6'(n % DEPTH), 6'd31};
      #1;
      if (busy) busy_cnt++;
      if (clr_done && done_at < 0) done_at = n;
      check_all();
      advance();
    end
    idle_inputs();
    chk("sweep_busy_cycles", 64'(busy_cnt), 64'd31);
    chk("sweep_done_cycle", 64'(done_at), 64'd32);
    for (int a = 0; a < DEPTH; a += 2) begin
      rd_addr = {6'(a + 1), 6'(a)};
      #1;
      chk("swept_rd0", rd_data[63:0], Z64);
      chk("swept_rd1", rd_data[127:64], Z64);
      chk("swept_pend", 64'(rd_pend), Z64);
      advance();
    end

    // Reset part-way through a sweep aborts it without a done pulse
    load_all(8'h72);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      rd_addr = {6'd31, 6'd10};
      cycle();
    end
    rd_addr = {6'd31, 6'd10};
    #1;
    chk("abort_r10_kept", rd_data[63:0], pat(10, 8'h72));
    chk("abort_r31_kept", rd_data[127:64], pat(31, 8'h72));
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_all();
    advance();
    rst = 1'b0;
    #1;
    chk("abort_busy_after", 64'(busy), Z64);
    late_done = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (clr_done) late_done++;
      check_all();
      advance();
    end
    chk("abort_no_done", 64'(late_done), Z64);

    // Randomised traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      wr0_en   = 1'($urandom_range(0, 1));
      wr0_ppp  = 3'($urandom_range(0, 7));
      wr0_addr = 6'($urandom_range(0, 39));
      wr0_data = {$urandom, $urandom};
      wr1_en   = 1'($urandom_range(0, 1));
      wr1_ppp  = 3'($urandom_range(0, 7));
      wr1_addr = ($urandom_range(0, 2) == 0) ? wr0_addr : 6'($urandom_range(0, 39));
      wr1_data = {$urandom, $urandom};
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 6'($urandom_range(0, 39));
      clr_req  = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < NUM_RD; k++) begin
        case ($urandom_range(0, 3))
          0:       t = {2'b00, wr0_addr};
          1:       t = {2'b00, wr1_addr};
          2:       t = {2'b00, rsv_addr};
          default: t = 8'($urandom_range(0, 39));
        endcase
        rd_addr[k*ADDR_W +: ADDR_W] = t[5:0];
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
